// File: rtl/util_dac_chan_unpack.sv
//==============================================================================
// Module   : util_dac_chan_unpack
// Brief    : Unpacks 4-slot DMA words into per-channel DAC samples by enable mask
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module util_dac_chan_unpack #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    dac_clk,
    input  logic                    dac_rst,
    input  logic [3:0]              dac_enable,
    input  logic                    dac_valid,
    output logic [4*DATA_WIDTH-1:0] dac_ddata,
    output logic                    dac_dunf,
    output logic [15:0]             dac_dunf_count,
    input  logic                    fifo_valid,
    input  logic [4*DATA_WIDTH-1:0] fifo_data,
    output logic                    fifo_ready
);

    logic [3:0]              r_enable;
    logic                    r_hold_valid;
    logic [1:0]              r_ptr;
    logic [4*DATA_WIDTH-1:0] r_hold;
    logic                    r_dunf;
    logic [15:0]             r_dunf_count;

    logic [2:0] w_k;
    logic [1:0] w_last_ptr;
    logic       w_active;
    logic       w_en_change;
    logic       w_consume;
    logic       w_underflow;
    logic       w_accept;
    logic [4*DATA_WIDTH-1:0] w_ddata;

    assign w_k = {2'b00, dac_enable[0]} + {2'b00, dac_enable[1]}
               + {2'b00, dac_enable[2]} + {2'b00, dac_enable[3]};

    // Samples per word minus one: 4 for one channel, 2 for two, 1 otherwise.
    assign w_last_ptr  = (w_k == 3'd1) ? 2'd3 : (w_k == 3'd2) ? 2'd1 : 2'd0;
    assign w_active    = (w_k != 3'd0);
    assign w_en_change = (dac_enable != r_enable);
    assign w_consume   = dac_valid && w_active && r_hold_valid;
    assign w_underflow = dac_valid && w_active && !r_hold_valid;

    assign fifo_ready = !dac_rst && !w_en_change && w_active &&
                        (!r_hold_valid || (dac_valid && (r_ptr == w_last_ptr)));
    assign w_accept   = fifo_valid && fifo_ready;

    always_comb begin
        logic [1:0] v_base;
        logic [1:0] v_j;
        logic [1:0] v_slot;
        w_ddata = '0;
        v_j     = 2'd0;
        v_slot  = 2'd0;
        // Slot base is ptr*stride; stride 4 only ever uses ptr = 0.
        v_base  = (w_k == 3'd1) ? r_ptr :
                  (w_k == 3'd2) ? {r_ptr[0], 1'b0} : 2'd0;
        if (r_hold_valid) begin
            for (int n = 0; n < 4; n++) begin
                if (dac_enable[n]) begin
                    v_slot = v_base + v_j;
                    w_ddata[n*DATA_WIDTH +: DATA_WIDTH] =
                        r_hold[int'(v_slot)*DATA_WIDTH +: DATA_WIDTH];
                    v_j = v_j + 2'd1;
                end
            end
        end
    end

    assign dac_ddata      = w_ddata;
    assign dac_dunf       = r_dunf;
    assign dac_dunf_count = r_dunf_count;

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            r_enable     <= 4'd0;
            r_hold_valid <= 1'b0;
            r_ptr        <= 2'd0;
            r_hold       <= '0;
            r_dunf       <= 1'b0;
            r_dunf_count <= 16'd0;
        end else begin
            r_enable <= dac_enable;
            if (w_en_change) begin
                r_hold_valid <= 1'b0;
                r_ptr        <= 2'd0;
            end else if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_ptr        <= 2'd0;
                r_hold       <= fifo_data;
            end else if (w_consume) begin
                if (r_ptr == w_last_ptr) begin
                    r_ptr        <= 2'd0;
                    r_hold_valid <= 1'b0;
                end else begin
                    r_ptr <= r_ptr + 2'd1;
                end
            end
            r_dunf <= w_underflow;
            if (w_underflow && (r_dunf_count != 16'hFFFF)) begin
                r_dunf_count <= r_dunf_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/util_dac_chan_unpack.md
UTIL_DAC_CHAN_UNPACK -- requirements
Module: util_dac_chan_unpack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the per-channel sample-word width in bits.
REQ-002 SHALL have port dac_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port dac_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port dac_enable, input, 4 bits: channel enables, bit N for channel N.
REQ-005 SHALL have port dac_valid, input, 1 bit: DAC core sample request, one sample set per cycle high.
REQ-006 SHALL have port dac_ddata, output, 4*DATA_WIDTH bits: channel N occupies bits [N*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port dac_dunf, output, 1 bit: underflow pulse.
REQ-008 SHALL have port dac_dunf_count, output, 16 bits: saturating underflow event counter.
REQ-009 SHALL have port fifo_valid, input, 1 bit: DMA word available.
REQ-010 SHALL have port fifo_data, input, 4*DATA_WIDTH bits: packed DMA word holding 4 slots, slot S at [S*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port fifo_ready, output, 1 bit: word accepted when fifo_valid and fifo_ready are both 1 at a clock edge.

Function
REQ-012 SHALL define k = number of set dac_enable bits, and stride K = k for k in {1,2,4}, K = 4 for k = 3; samples per word P = 4/K.
REQ-013 SHALL hold one accepted word in a holding register with flag hold_valid and sample pointer ptr (0..P-1).
REQ-014 SHALL drive dac_ddata combinationally from the holding register: the j-th enabled channel in ascending index order takes slot ptr*K + j; disabled channels are driven 0.
REQ-015 SHALL, for k = 3, ignore slot 3 of every word.
REQ-016 SHALL drive dac_ddata all-zero whenever hold_valid = 0.
REQ-017 SHALL consume one sample set on each edge where dac_valid = 1, k > 0 and hold_valid = 1: ptr increments; when ptr = P-1 it wraps to 0 and the word is released.
REQ-018 SHALL assert fifo_ready = (k > 0) and (hold_valid = 0 or (dac_valid = 1 and ptr = P-1)); a combinational path from dac_valid to fifo_ready is permitted.
REQ-019 SHALL load fifo_data with ptr = 0 on acceptance, so back-to-back words incur no bubble when fifo_valid stays high.
REQ-020 SHALL, on an edge where the word is released and no new word is accepted, clear hold_valid.
REQ-021 SHALL treat dac_valid = 1, k > 0, hold_valid = 0 as underflow: dac_dunf = 1 in the following cycle for exactly one cycle per event, and dac_dunf_count increments, saturating at 0xFFFF.
REQ-022 SHALL NOT count underflow when k = 0; with k = 0, fifo_ready = 0 and dac_ddata = 0.
REQ-023 SHALL register dac_enable; on any edge where dac_enable differs from its registered value, clear hold_valid and ptr, discarding the held word; fifo_ready is 0 in that cycle.
REQ-024 SHALL, on a word acceptance coincident with an underflow request (hold_valid = 0, dac_valid = 1), count underflow and load the word with ptr = 0, not consuming from it.

Reset
REQ-025 SHALL, while dac_rst = 1 at an edge, clear hold_valid, ptr, the registered enables, dac_dunf and dac_dunf_count to 0; fifo_ready is 0 while dac_rst = 1.
REQ-026 SHALL discard a partially consumed word when reset is asserted mid-operation; after release, the first accepted word starts at ptr = 0.
REQ-027 SHALL hold dac_ddata = 0 after reset until the first word is accepted.

Verification
REQ-028 SHALL cover: enable = 4'b1111, dac_valid continuously high, words W0,W1 back-to-back -> dac_ddata = W0 then W1, fifo_ready high every cycle, no dac_dunf.
REQ-029 SHALL cover: enable = 4'b0101, word with slots {S3,S2,S1,S0} -> cycle 1: ch0 = S0, ch2 = S1; cycle 2: ch0 = S2, ch2 = S3; ch1 = ch3 = 0; one fifo_ready handshake per 2 requests.
REQ-030 SHALL cover: enable = 4'b1011 (k = 3) -> ch0 = S0, ch1 = S1, ch3 = S2, S3 ignored, one word per request.
REQ-031 SHALL cover: fifo_valid = 0 with dac_valid high for 3 cycles -> dac_ddata = 0, dac_dunf pulses 3 times, dac_dunf_count = 3; then 0xFFFF saturation holds after further events.
REQ-032 SHALL cover: enable = 4'b0001 after 1 of 4 samples consumed, enable changed to 4'b0011 -> held word dropped, next word starts at slot 0.
REQ-033 SHALL cover: dac_rst pulse mid-word -> all outputs 0 next cycle, count = 0, next word starts at ptr = 0.
